pixel_frame_serializer: RTL and testbench
=========================================

Name: pixel_frame_serializer

Overview:
Sink-side reader for the parallel frame word produced by the pixel sensor top level (N pixels x 8 bits, binary-converted).
- Captures a complete frame into a shadow buffer on a one-cycle frame-valid pulse.
- Streams the frame out one pixel per transfer over a valid/ready byte interface, in pixel-index order.
- Sits between the pixel top and downstream consumers (e.g. a link or memory writer), so the sensor FSM is never stalled by backpressure.

Parameters:
H, 4, pixel array rows
W, 4, pixel array columns
N, 16, total pixels; must equal H*W (elaboration error otherwise)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
frameIn  input  N*8  parallel frame; pixel k = frameIn[8k+:8], k = row*W + col
frameValid  input  1  one-cycle pulse: frameIn holds a complete frame this cycle
pixOut  output  8  current pixel byte
pixValid  output  1  pixOut/pixIndex/pixLast valid
pixReady  input  1  downstream accepts the beat when pixValid && pixReady
pixIndex  output  clog2(N)  index k of the pixel on pixOut
pixLast  output  1  high with the beat for k = N-1
frameDropped  output  1  one-cycle pulse: an incoming frame was discarded
busy  output  1  high while a frame is held or streaming

Behaviour:
- Reset (async assert, released on clk) drives all of the following to 0:
  - outputs pixOut, pixValid, pixIndex, pixLast, frameDropped, busy;
  - the shadow buffer;
  - FSM state goes to IDLE.
- Reset mid-stream abandons the frame; no further beats from it.
- FSM states: IDLE, STREAM.
- IDLE:
  - frameValid=1 -> capture frameIn into the shadow buffer; go to STREAM.
  - Next cycle: pixValid=1, pixIndex=0, pixOut=pixel 0, busy=1.
  - Capture-to-first-valid latency is exactly 1 cycle.
- STREAM:
  - A transfer is any cycle with pixValid && pixReady.
  - On a transfer with pixIndex < N-1: pixIndex increments and pixOut updates next cycle.
  - Stalls: while pixValid && !pixReady, pixOut, pixIndex and pixLast hold stable. pixValid never drops without a transfer.
  - pixLast = (pixIndex == N-1) && pixValid.
  - Transfer of index N-1 with no new frame accepted -> IDLE; next cycle pixValid=0, busy=0, pixIndex=0.
- frameValid while in STREAM:
  - Same cycle as the final transfer (index N-1 handshake): the new frame is captured. Next cycle pixValid stays 1, pixIndex=0, new pixel 0 (zero-bubble back-to-back).
  - Any other cycle: handled per the optional feature; the current stream is never corrupted.
- frameDropped is registered: it pulses 1 cycle after the discarded frameValid.
- Throughput: one pixel per cycle with pixReady held high; an N-pixel frame takes N cycles.
- pixIndex wraps to 0 only at frame boundaries, never mid-frame.

Optional Feature:
Macro PIXEL_SER_PENDING_EN.
- Defined: adds a one-deep pending frame buffer.
  - frameValid during STREAM (not on the final transfer) stores the frame in pending if pending is empty. No drop.
  - On the final transfer, the pending frame moves to the shadow buffer and streaming continues with no bubble (pixValid stays 1, pixIndex=0).
  - frameValid while pending is full -> new frame discarded, frameDropped pulses. The pending frame is kept.
  - busy stays high while pending is full.
  - Final transfer with pending full plus a simultaneous frameValid: pending moves to shadow and the new frame enters pending. No drop.
- Undefined: no pending buffer. Any frameValid during STREAM, except on the final transfer, is discarded with a frameDropped pulse.

Test Plan:
- Basic stream (H=W=4, pixReady=1): frame with pixel k = 8'h10+k, one frameValid pulse.
  - Response: starting 1 cycle later, 16 consecutive beats 0x10..0x1F, pixIndex 0..15, pixLast only on 0x1F.
  - Then pixValid=0, busy=0.
- Backpressure: same frame; pixReady low for 3 cycles at index 5, and on alternate cycles thereafter.
  - Response: pixOut=0x15 held stable with pixValid=1 throughout the stall; no beat lost or duplicated; 16 total transfers.
- Back-to-back: frame A (0x00+k), then frame B (0x80+k) pulsed on the cycle of A's index-15 handshake.
  - Response: next cycle pixOut=0x80, pixIndex=0, no idle cycle; all 32 beats in order.
- Overlap drop (macro off): frame B pulsed while A is at index 7.
  - Response: frameDropped pulse 1 cycle later; A completes unchanged (0x00..0x0F); no B beats; IDLE afterwards.
- Pending (macro on): B at A index 7, C at A index 9.
  - Response: C dropped (1 frameDropped pulse); B streams immediately after A's last beat with no bubble.
- Reset mid-stream: assert reset at index 9.
  - Response: all outputs 0 within the same cycle (async).
  - After release, a new frame (0x40+k) streams from index 0 with correct values.

Source files
------------

// File: rtl/pixel_frame_serializer.sv
// rtl/pixel_frame_serializer.sv - captures an N-pixel parallel frame and streams it one byte per beat
// Optional one-deep pending frame buffer: define PIXEL_SER_PENDING_EN.
module pixel_frame_serializer #(
  parameter int H = 4,
  parameter int W = 4,
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*8-1:0]       frameIn,
  input  logic                 frameValid,
  output logic [7:0]           pixOut,
  output logic                 pixValid,
  input  logic                 pixReady,
  output logic [$clog2(N)-1:0] pixIndex,
  output logic                 pixLast,
  output logic                 frameDropped,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (N != H * W) begin : g_bad_size
    $error("pixel_frame_serializer: N must equal H*W");
  end

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state;
  logic [N-1:0][7:0]   shadow;
  logic [N-1:0][7:0]   load_data;
  logic [IW-1:0]       idx_next;
  logic                xfer;
  logic                last_xfer;
  logic                load_new;
  logic                load_pend;
  logic                drop;
  logic                pend_full;

`ifdef PIXEL_SER_PENDING_EN
  logic [N-1:0][7:0]   pend;
  logic                accept_pend;
`endif

  // Handshake and frame-acceptance decisions for this cycle
  always_comb begin
    xfer      = pixValid && pixReady;
    last_xfer = xfer && (pixIndex == LAST);
    idx_next  = pixIndex + IW'(1);
`ifdef PIXEL_SER_PENDING_EN
    load_pend   = last_xfer && pend_full;
    load_new    = frameValid && !load_pend && ((state == IDLE) || last_xfer);
    accept_pend = frameValid && (state == STREAM) &&
                  ((!last_xfer && !pend_full) || load_pend);
    drop        = frameValid && (state == STREAM) && !last_xfer && pend_full;
    load_data   = load_pend ? pend : frameIn;
`else
    load_pend = 1'b0;
    load_new  = frameValid && ((state == IDLE) || last_xfer);
    drop      = frameValid && (state == STREAM) && !last_xfer;
    load_data = frameIn;
`endif
  end

`ifdef PIXEL_SER_PENDING_EN
  // Pending slot: filled by a mid-stream frame, drained into the shadow on the final beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend      <= '0;
      pend_full <= 1'b0;
    end else begin
      if (accept_pend) pend <= frameIn;
      if (load_pend)
        pend_full <= accept_pend;
      else if (accept_pend)
        pend_full <= 1'b1;
    end
  end
`else
  assign pend_full = 1'b0;
`endif

  // Stream FSM: shadow capture, beat sequencing and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shadow       <= '0;
      pixOut       <= '0;
      pixValid     <= 1'b0;
      pixIndex     <= '0;
      pixLast      <= 1'b0;
      frameDropped <= 1'b0;
      busy         <= 1'b0;
    end else begin
      frameDropped <= drop;
      if (load_new || load_pend) begin
        state    <= STREAM;
        shadow   <= load_data;
        pixOut   <= load_data[0];
        pixIndex <= '0;
        pixLast  <= (N == 1);
        pixValid <= 1'b1;
        busy     <= 1'b1;
      end else if (last_xfer) begin
        state    <= IDLE;
        pixOut   <= '0;
        pixIndex <= '0;
        pixLast  <= 1'b0;
        pixValid <= 1'b0;
        busy     <= pend_full;
      end else if (xfer) begin
        pixIndex <= idx_next;
        pixOut   <= shadow[idx_next];
        pixLast  <= (idx_next == LAST);
      end
    end
  end

endmodule

// File: tb/tb_pixel_frame_serializer.sv
// tb/tb_pixel_frame_serializer.sv - randomized self-checking bench against a frame-queue reference model
module tb_pixel_frame_serializer;

  localparam int H = 4;
  localparam int W = 4;
  localparam int N = 16;
`ifdef PIXEL_SER_PENDING_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N*8-1:0] frameIn;
  logic           frameValid;
  logic [7:0]     pixOut;
  logic           pixValid;
  logic           pixReady;
  logic [3:0]     pixIndex;
  logic           pixLast;
  logic           frameDropped;
  logic           busy;

  pixel_frame_serializer #(.H(H), .W(W), .N(N)) dut (
    .clk(clk), .reset(reset), .frameIn(frameIn), .frameValid(frameValid),
    .pixOut(pixOut), .pixValid(pixValid), .pixReady(pixReady),
    .pixIndex(pixIndex), .pixLast(pixLast), .frameDropped(frameDropped),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_q[$];     // expected beats, each (index << 8) | byte
  bit exp_drop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N*8-1:0] pattern(input int base);
    logic [N*8-1:0] f;
    for (int k = 0; k < N; k++) f[8*k +: 8] = 8'(base + k);
    return f;
  endfunction

  function automatic logic [N*8-1:0] rnd_frame();
    logic [N*8-1:0] f;
    for (int k = 0; k < N; k++) f[8*k +: 8] = 8'($urandom);
    return f;
  endfunction

  // One clock: drive, compare against the model at negedge, advance the model
  task automatic step(input bit fv, input logic [N*8-1:0] f, input bit rdy);
    int frames;
    bit xfer;
    bit fin;
    frameValid = fv;
    frameIn    = f;
    pixReady   = rdy;
    @(negedge clk);
    check("frameDropped", {31'b0, frameDropped}, {31'b0, exp_drop});
    if (exp_q.size() > 0) begin
      check("pixValid", {31'b0, pixValid}, 1);
      check("busy", {31'b0, busy}, 1);
      check("pixOut", {24'b0, pixOut}, exp_q[0] & 8'hff);
      check("pixIndex", {28'b0, pixIndex}, exp_q[0] >> 8);
      check("pixLast", {31'b0, pixLast}, ((exp_q[0] >> 8) == N - 1) ? 1 : 0);
    end else begin
      check("idle_pixValid", {31'b0, pixValid}, 0);
      check("idle_busy", {31'b0, busy}, 0);
      check("idle_pixIndex", {28'b0, pixIndex}, 0);
      check("idle_pixLast", {31'b0, pixLast}, 0);
    end
    frames = (exp_q.size() + N - 1) / N;
    xfer   = (exp_q.size() > 0) && rdy;
    fin    = xfer && ((exp_q[0] >> 8) == N - 1);
    if (xfer) void'(exp_q.pop_front());
    exp_drop = 0;
    if (fv) begin
      if (frames - int'(fin) < CAP) begin
        for (int k = 0; k < N; k++) exp_q.push_back((k << 8) | int'(f[8*k +: 8]));
      end else begin
        exp_drop = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int k);
    bit hit = 0;
    for (int i = 0; i < 4 * N && !hit; i++) begin
      if (exp_q.size() > 0 && (exp_q[0] >> 8) == k) hit = 1;
      else step(0, '0, 1);
    end
    check("reach_index", {31'b0, hit}, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 * N && exp_q.size() > 0; i++) step(0, '0, 1);
    check("drain_done", exp_q.size(), 0);
    step(0, '0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pixOut"}, {24'b0, pixOut}, 0);
    check({tag, "_pixValid"}, {31'b0, pixValid}, 0);
    check({tag, "_pixIndex"}, {28'b0, pixIndex}, 0);
    check({tag, "_pixLast"}, {31'b0, pixLast}, 0);
    check({tag, "_frameDropped"}, {31'b0, frameDropped}, 0);
    check({tag, "_busy"}, {31'b0, busy}, 0);
  endtask

  initial begin
    reset = 1'b1; frameValid = 1'b0; frameIn = '0; pixReady = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic stream
    step(1, pattern(8'h10), 1);
    drain();

    // Backpressure: 3-cycle stall at index 5, then alternate ready
    step(1, pattern(8'h10), 1);
    run_to(5);
    for (int i = 0; i < 3; i++) step(0, '0, 0);
    for (int i = 0; i < 8 * N && exp_q.size() > 0; i++) step(0, '0, i[0]);
    drain();

    // Back-to-back on the final handshake
    step(1, pattern(8'h00), 1);
    run_to(15);
    step(1, pattern(8'h80), 1);
    drain();

    // Overlapping frame at index 7
    step(1, pattern(8'h00), 1);
    run_to(7);
    step(1, pattern(8'h80), 1);
    drain();

    // Two overlapping frames at indices 7 and 9
    step(1, pattern(8'h00), 1);
    run_to(7);
    step(1, pattern(8'h80), 1);
    run_to(9);
    step(1, pattern(8'hC0), 1);
    drain();

    // Asynchronous reset mid-stream at index 9
    step(1, pattern(8'h00), 1);
    run_to(9);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    exp_drop = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    step(1, pattern(8'h40), 1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 11) == 0), rnd_frame(), ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
